pong_game_ctrl: RTL
===================

Name: pong_game_ctrl

Overview:
Game-flow sequencer for Classic Pong. It sits between the UART start pulse, the ball/paddle datapath and the score display. It steps the game through idle, serve, play, point and game-over phases, keeps both scores and decides the winner. It also drives the ball run/reset controls, the serve direction and the paddle enable. Frame-based delays are timed from the Vsync_i the game already receives.

Parameters:
WIN_SCORE, 9, points needed to win; 1..(2^SCORE_WIDTH)-1
SCORE_WIDTH, 4, width of each score counter
SERVE_DELAY_FRAMES, 60, frames between ball reset and ball release; >=1
POINT_HOLD_FRAMES, 90, frames the scored state is held before the next serve; >=1

Ports:
clk_i  in  1  system clock (25 MHz pixel clock)
rst_n_i  in  1  asynchronous reset, active-low
Vsync_i  in  1  VGA vertical sync from sync-pulse generator; high during active rows
Game_Start_i  in  1  single-cycle start pulse (UART rx_dv)
P1_Miss_i  in  1  ball passed the P1 (left) paddle; level, sampled only in PLAY
P2_Miss_i  in  1  ball passed the P2 (right) paddle; level, sampled only in PLAY
Ball_Run_o  out  1  ball motion enable
Ball_Reset_o  out  1  single-cycle pulse: recentre the ball
Serve_Dir_o  out  1  0 = serve toward P1 (left), 1 = toward P2 (right)
Paddle_En_o  out  1  paddle movement enable
P1_Score_o  out  SCORE_WIDTH  player 1 score
P2_Score_o  out  SCORE_WIDTH  player 2 score
Winner_o  out  2  00 none, 01 P1, 10 P2
State_o  out  3  current state encoding, for debug and display

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-game) forces state IDLE, scores 0, Winner_o 00, Ball_Run_o 0, Ball_Reset_o 0, Serve_Dir_o 1, Paddle_En_o 0, frame counter 0 and Vsync history reg 0.
- Frame tick: registered history of Vsync_i. A tick is the 1->0 transition, asserted for one cycle, in the cycle after the falling edge is sampled.
- Frame counter clears on every state entry and increments on each tick.
- States: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4. Values 5..7 are illegal and recover to IDLE on the next clock.
- IDLE:
  - Ball_Run_o=0, Paddle_En_o=0.
  - On Game_Start_i: clear scores, Serve_Dir_o<=1, pulse Ball_Reset_o, go to SERVE_WAIT.
- SERVE_WAIT:
  - Paddle_En_o=1, Ball_Run_o=0.
  - On the tick where counter == SERVE_DELAY_FRAMES-1, go to PLAY.
- PLAY:
  - Ball_Run_o=1, Paddle_En_o=1.
  - P1_Miss_i alone: P2 score +1, Serve_Dir_o<=0 (serve toward the conceding player).
  - P2_Miss_i alone: P1 score +1, Serve_Dir_o<=1.
  - Both in the same cycle: no score change, Serve_Dir_o unchanged, go to POINT (replay).
  - After a score, if the new score == WIN_SCORE: set Winner_o and go to GAME_OVER. Otherwise go to POINT.
  - Ball_Run_o is 0 in the cycle after the miss is sampled. Leaving PLAY makes miss sampling one-shot.
- POINT:
  - Ball_Run_o=0, Paddle_En_o=1.
  - On the tick where counter == POINT_HOLD_FRAMES-1: pulse Ball_Reset_o and go to SERVE_WAIT.
- GAME_OVER:
  - Ball_Run_o=0, Paddle_En_o=0.
  - Scores and Winner_o are held.
  - On Game_Start_i: clear scores and Winner_o, Serve_Dir_o<=1, pulse Ball_Reset_o, go to SERVE_WAIT.
- Game_Start_i is ignored in SERVE_WAIT, PLAY and POINT.
- Scores never exceed WIN_SCORE; no wrap-around.
- Score increments are SCORE_WIDTH unsigned.
- Tick coincident with a state transition: the counter clears and that tick is not counted in the new state.

Decomposition:
- Package pong_ctrl_pkg:
  - state encodings (IDLE..GAME_OVER)
  - SERVE_LEFT=0, SERVE_RIGHT=1
  - WINNER_NONE/P1/P2 codes
- One sub-module, pong_frame_timer:
  - Vsync falling-edge detect plus frame counter
  - inputs: clear, Vsync
  - outputs: tick, count
- The FSM, scores and output registers stay in pong_game_ctrl.

Test Plan (WIN_SCORE=3, SERVE_DELAY_FRAMES=2, POINT_HOLD_FRAMES=3):
- Reset, then Game_Start_i pulse -> Ball_Reset_o high exactly 1 cycle, State_o=1. After 2 Vsync falling edges, State_o=2 and Ball_Run_o=1.
- In PLAY, P2_Miss_i for 5 cycles -> P1_Score_o=1 (not 5), Serve_Dir_o=1, State_o=3. After 3 frames: Ball_Reset_o pulse, then State_o=1.
- P1_Miss_i and P2_Miss_i asserted together in PLAY -> both scores unchanged, State_o=3, Serve_Dir_o unchanged.
- P1 wins three rallies -> P1_Score_o=3, Winner_o=01, State_o=4, Ball_Run_o=0. A further miss or Vsync activity leaves the score at 3.
- Game_Start_i in PLAY -> ignored. Game_Start_i in GAME_OVER -> scores 0, Winner_o=00, State_o=1.
- rst_n_i low mid-PLAY, asynchronously between clock edges -> all outputs at reset values before the next edge. No tick is generated from the stale Vsync history after release.

Source files
------------

// File: rtl/pong_ctrl_pkg.sv
// Shared encodings for the Pong game-flow sequencer.
// States, serve directions and winner codes.
package pong_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_PLAY       = 3'd2,
        ST_POINT      = 3'd3,
        ST_GAME_OVER  = 3'd4
    } state_e;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

endpackage

// File: rtl/pong_frame_timer.sv
// Frame tick from Vsync falling edge plus a clearable frame counter.
// Ports: clk_i, rst_n_i, clear_i, vsync_i -> tick_o, count_o.
module pong_frame_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             vsync_i,
    output logic             tick_o,
    output logic [CNT_W-1:0] count_o
);

    logic [1:0] vs_q;

    // Edge is seen between the two history stages, so the tick
    // comes one cycle after the low level is first sampled.
    assign tick_o = vs_q[1] & ~vs_q[0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vs_q    <= 2'b00;
            count_o <= '0;
        end else begin
            vs_q <= {vs_q[0], vsync_i};
            if (clear_i)
                count_o <= '0;
            else if (tick_o)
                count_o <= count_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: phases, scores, winner, ball/paddle controls.
// In: clk_i, rst_n_i, Vsync_i, Game_Start_i, P1/P2_Miss_i. Out: ball, paddle, scores, state.
module pong_game_ctrl
    import pong_ctrl_pkg::*;
#(
    parameter int WIN_SCORE          = 9,
    parameter int SCORE_WIDTH        = 4,
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int POINT_HOLD_FRAMES  = 90
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   Vsync_i,
    input  logic                   Game_Start_i,
    input  logic                   P1_Miss_i,
    input  logic                   P2_Miss_i,
    output logic                   Ball_Run_o,
    output logic                   Ball_Reset_o,
    output logic                   Serve_Dir_o,
    output logic                   Paddle_En_o,
    output logic [SCORE_WIDTH-1:0] P1_Score_o,
    output logic [SCORE_WIDTH-1:0] P2_Score_o,
    output logic [1:0]             Winner_o,
    output logic [2:0]             State_o
);

    localparam int MAX_F = (SERVE_DELAY_FRAMES > POINT_HOLD_FRAMES)
                         ? SERVE_DELAY_FRAMES : POINT_HOLD_FRAMES;
    localparam int CNT_W = $clog2(MAX_F + 1);

    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(POINT_HOLD_FRAMES - 1);
    localparam logic [SCORE_WIDTH-1:0] WIN  = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [SCORE_WIDTH-1:0] ONE  = SCORE_WIDTH'(1);

    state_e                 state_q, state_n;
    logic [SCORE_WIDTH-1:0] p1_n, p2_n;
    logic [1:0]             win_n;
    logic                   dir_n;
    logic                   bres_n;
    logic                   tick;
    logic [CNT_W-1:0]       count;

    // Counter restarts on every state entry, dropping a coincident tick.
    pong_frame_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear_i (state_n != state_q),
        .vsync_i (Vsync_i),
        .tick_o  (tick),
        .count_o (count)
    );

    always_comb begin
        state_n = state_q;
        p1_n    = P1_Score_o;
        p2_n    = P2_Score_o;
        win_n   = Winner_o;
        dir_n   = Serve_Dir_o;
        bres_n  = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (Game_Start_i) begin
                    p1_n    = '0;
                    p2_n    = '0;
                    win_n   = WINNER_NONE;
                    dir_n   = SERVE_RIGHT;
                    bres_n  = 1'b1;
                    state_n = ST_SERVE_WAIT;
                end
            end
            ST_SERVE_WAIT: begin
                if (tick && count == SERVE_LAST)
                    state_n = ST_PLAY;
            end
            ST_PLAY: begin
                if (P1_Miss_i && P2_Miss_i) begin
                    state_n = ST_POINT;
                end else if (P1_Miss_i) begin
                    dir_n   = SERVE_LEFT;
                    state_n = ST_POINT;
                    if (P2_Score_o < WIN)
                        p2_n = P2_Score_o + ONE;
                    if (p2_n == WIN) begin
                        win_n   = WINNER_P2;
                        state_n = ST_GAME_OVER;
                    end
                end else if (P2_Miss_i) begin
                    dir_n   = SERVE_RIGHT;
                    state_n = ST_POINT;
                    if (P1_Score_o < WIN)
                        p1_n = P1_Score_o + ONE;
                    if (p1_n == WIN) begin
                        win_n   = WINNER_P1;
                        state_n = ST_GAME_OVER;
                    end
                end
            end
            ST_POINT: begin
                if (tick && count == HOLD_LAST) begin
                    bres_n  = 1'b1;
                    state_n = ST_SERVE_WAIT;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            P1_Score_o   <= '0;
            P2_Score_o   <= '0;
            Winner_o     <= WINNER_NONE;
            Serve_Dir_o  <= SERVE_RIGHT;
            Ball_Run_o   <= 1'b0;
            Ball_Reset_o <= 1'b0;
            Paddle_En_o  <= 1'b0;
        end else begin
            state_q      <= state_n;
            P1_Score_o   <= p1_n;
            P2_Score_o   <= p2_n;
            Winner_o     <= win_n;
            Serve_Dir_o  <= dir_n;
            Ball_Run_o   <= (state_n == ST_PLAY);
            Ball_Reset_o <= bres_n;
            Paddle_En_o  <= (state_n == ST_SERVE_WAIT) ||
                            (state_n == ST_PLAY) ||
                            (state_n == ST_POINT);
        end
    end

    assign State_o = state_q;

endmodule
